// File: rtl/ex_mdu_ctrl.sv
// Sequencer for the EX-stage iterative multiply/divide unit: radix-2 shift-add
// multiply and restoring divide, one result bit per cycle, with pipeline stall.
//
// state | meaning
// IDLE  | waiting for an accepted M-extension op
// CALC  | one multiply/divide iteration per cycle, N cycles
// FIXUP | sign correction and result selection
// DONE  | result valid, done pulse, pipeline released
module ex_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_f3;
    logic                r_word;
    logic                r_a_neg;
    logic                r_b_neg;
    logic [XLEN-1:0]     r_mag;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;

    logic                w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_eff, w_b_eff, w_a_mag, w_b_mag;
    logic                w_a_min, w_div0, w_ovf, w_special, w_accept;
    logic [XLEN-1:0]     w_spec_raw, w_spec_res;

    // Word multiplies only need the low 32 product bits, so operands stay unsigned.
    assign w_is_div = funct3[2];
    assign w_a_sgn  = w_is_div ? ~funct3[0] : (~is_word & (funct3 == 3'b001 || funct3 == 3'b010));
    assign w_b_sgn  = w_is_div ? ~funct3[0] : (~is_word & (funct3 == 3'b001));
    assign w_a_eff  = is_word ? {{(XLEN-32){w_a_sgn & op_a[31]}}, op_a[31:0]} : op_a;
    assign w_b_eff  = is_word ? {{(XLEN-32){w_b_sgn & op_b[31]}}, op_b[31:0]} : op_b;
    assign w_a_neg  = w_a_sgn & w_a_eff[XLEN-1];
    assign w_b_neg  = w_b_sgn & w_b_eff[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a_eff : w_a_eff;
    assign w_b_mag  = w_b_neg ? -w_b_eff : w_b_eff;

    assign w_a_min   = is_word ? (op_a[31:0] == 32'h8000_0000)
                               : (op_a == {1'b1, {(XLEN-1){1'b0}}});
    assign w_div0    = w_is_div & (w_b_eff == '0);
    assign w_ovf     = w_is_div & ~funct3[0] & w_a_min & (w_b_eff == '1);
    assign w_special = w_div0 | w_ovf;
    assign w_spec_raw = w_div0 ? (funct3[1] ? w_a_eff : '1)
                               : (funct3[1] ? '0 : w_a_eff);
    assign w_spec_res = is_word ? {{(XLEN-32){w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
    assign w_accept   = (r_state == S_IDLE) & start & ~flush;

    logic [XLEN:0]       w_msum, w_dtop, w_ddiff;
    logic                w_dge;
    logic [2*XLEN-1:0]   w_mul_next, w_div_next;

    // Multiply shifts right with the carry re-entering at the top; divide shifts left.
    assign w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mag : '0)};
    assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};
    assign w_dtop     = r_acc[2*XLEN-1:XLEN-1];
    assign w_ddiff    = w_dtop - {1'b0, r_mag};
    assign w_dge      = ~w_ddiff[XLEN];
    assign w_div_next = {(w_dge ? w_ddiff[XLEN-1:0] : w_dtop[XLEN-1:0]), r_acc[XLEN-2:0], w_dge};

    logic [2*XLEN-1:0]   w_prod, w_prod_s;
    logic [XLEN-1:0]     w_quo_s, w_rem_s, w_fix_raw, w_fix_res;

    assign w_prod    = r_word ? (r_acc >> (XLEN-32)) : r_acc;
    assign w_prod_s  = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
    assign w_quo_s   = (r_a_neg ^ r_b_neg) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_s   = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix_raw = r_f3[2] ? (r_f3[1] ? w_rem_s : w_quo_s)
                     : ((r_word || r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0]
                                                       : w_prod_s[2*XLEN-1:XLEN]);
    assign w_fix_res = r_word ? {{(XLEN-32){w_fix_raw[31]}}, w_fix_raw[31:0]} : w_fix_raw;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = w_special ? S_DONE : S_CALC;
                S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_FIXUP;
                S_FIXUP: w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_word   <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_mag    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_f3    <= funct3;
                r_word  <= is_word;
                r_a_neg <= w_a_neg;
                r_b_neg <= w_b_neg;
                r_cnt   <= is_word ? CW'(32) : CW'(XLEN);
                r_mag   <= w_is_div ? w_b_mag : w_a_mag;
                // Word dividends sit in the upper half so 32 steps consume exactly their bits.
                r_acc   <= w_is_div ? {{XLEN{1'b0}}, (is_word ? (w_a_mag << 32) : w_a_mag)}
                                    : {{XLEN{1'b0}}, w_b_mag};
                if (w_special) r_result <= w_spec_res;
            end else if (r_state == S_CALC && !flush) begin
                r_acc <= r_f3[2] ? w_div_next : w_mul_next;
                r_cnt <= r_cnt - CW'(1);
            end else if (r_state == S_FIXUP && !flush) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign stall  = w_accept | (r_state == S_CALC) | (r_state == S_FIXUP);
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE) & ~flush;
    assign result = r_result;
endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Scoreboard bench for ex_mdu_ctrl: directed ops push expected result and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_ex_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, flush, is_word;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b, result;
    logic        stall, busy, done;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] last_exp = '0;

    logic [63:0] sb_res[$];
    int          sb_cyc[$];
    string       sb_name[$];

    ex_mdu_ctrl #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .funct3(funct3), .is_word(is_word), .op_a(op_a), .op_b(op_b),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        string nm;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_res.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                nm = sb_name.pop_front();
                chk({nm, "_result"}, result, sb_res.pop_front());
                chk({nm, "_cycle"}, 64'(cyc), 64'(sb_cyc.pop_front()));
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after DONE.
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat,
                          input string nm);
        bit stall_ok = 1'b1;
        bit seen = 1'b0;
        sb_res.push_back(exp);
        sb_cyc.push_back(cyc + lat);
        sb_name.push_back(nm);
        start = 1'b1; funct3 = f3; is_word = w; op_a = a; op_b = b;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        for (int k = 1; k <= lat + 5 && !seen; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            op_a = 64'hA5A5_5A5A_DEAD_BEEF;
            op_b = 64'h0123_4567_89AB_CDEF;
            if (done === 1'b1) begin
                seen = 1'b1;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        chk({nm, "_seen_done"}, 64'(seen), 64'd1);
        chk({nm, "_stall"}, 64'(stall_ok), 64'd1);
        last_exp = exp;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; is_word = 1'b0;
        op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'd0);
        @(posedge clk); #1;

        run_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul_7_m3");
        run_op(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu_ones");
        run_op(3'b001, 1'b0, '1, '1, 64'd0, 66, "mulh_m1");
        run_op(3'b010, 1'b0, '1, 64'd2, '1, 66, "mulhsu_m1_2");
        run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div_m7_2");
        run_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66, "rem_m7_2");
        run_op(3'b101, 1'b0, 64'd100, 64'd0, '1, 1, "divu_by0");
        run_op(3'b111, 1'b0, 64'd100, 64'd0, 64'd100, 1, "remu_by0");
        run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf");
        run_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf");
        run_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
        run_op(3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, '1, 34, "remw_m7_2");
        run_op(3'b101, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, "divuw");
        run_op(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, "mulw");

        // Flush at cycle 10 of a divide: no done pulse, result untouched.
        start = 1'b1; funct3 = 3'b100; is_word = 1'b0;
        op_a = 64'hFFFF_FFFF_FFFF_FFF9; op_b = 64'd2;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        chk("flush_c10_busy", 64'(busy), 64'd1);
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_c11_busy", 64'(busy), 64'd0);
        chk("flush_c11_stall", 64'(stall), 64'd0);
        chk("flush_c11_result", result, last_exp);
        repeat (70) @(posedge clk);
        #1;

        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 64'd3; op_b = 64'd5;
        #1;
        chk("start_flush_stall", 64'(stall), 64'd0);
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", 64'(busy), 64'd0);
        repeat (70) @(posedge clk);
        #1;

        // Reset at cycle 20 of a multiply.
        start = 1'b1; funct3 = 3'b000; is_word = 1'b0; op_a = 64'd9; op_b = 64'd9;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        chk("rst_c21_busy", 64'(busy), 64'd0);
        chk("rst_c21_stall", 64'(stall), 64'd0);
        chk("rst_c21_done", 64'(done), 64'd0);
        chk("rst_c21_result", result, 64'd0);
        repeat (80) @(posedge clk);
        #1;

        run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, "divu_after_rst");
        run_op(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66, "remu_b2b");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb_res.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mdu_ctrl.md
# ex_mdu_ctrl

Sequencing controller for the iterative multiply/divide unit in the EX stage. It accepts an M-extension operation on the operands and decoded fields that ID/EX supplies, then runs a radix-2 shift-add multiply or restoring divide over several cycles. While it runs, it holds the EX stage stalled, and it presents a single-cycle-valid result to the EX/MEM path. Single-cycle ALU operations bypass this block entirely.

## Interface
Parameters:
- XLEN, 64, datapath width; operand and result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  a valid M-extension operation is present in EX this cycle.
- flush  in  1  kill any in-flight operation (branch redirect or exception).
- funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- is_word  in  1  RV64 *W variant (opcode OP-32).
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- stall  out  1  hold PC, IF/ID and ID/EX this cycle.
- busy  out  1  FSM not in IDLE.
- done  out  1  result valid this cycle; one-cycle pulse.
- result  out  XLEN  final result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE with start=1 and flush=0 means the operation is accepted:
  - Latch funct3 and is_word.
  - Compute sign flags:
    - Multiply: op_a is signed for mulh/mulhsu; op_b is signed for mulh only.
    - Divide: both operands are signed for div/rem.
  - Latch operand magnitudes.
  - Load iteration counter with N = 32 if is_word, else XLEN.
- Word operands: use bits [31:0] only. Sign-extend for signed ops and zero-extend for unsigned ops before taking magnitudes.
- Word ops with funct3 001/010/011 are not legal RV64 encodings; treat them as mulw.
- Special cases, detected in IDLE at accept, go IDLE→DONE with no CALC:
  - Divide by zero (effective divisor 0): quotient = all ones; remainder = effective dividend.
  - Signed overflow (dividend = most-negative, divisor = −1, div/rem only): quotient = dividend; remainder = 0.
- CALC, one bit per cycle, for N cycles; counter decrements and CALC→FIXUP when it reaches 0.
  - Multiply: 2·XLEN-bit partial product; add multiplicand if multiplier LSB set; shift.
  - Divide: shift remainder/quotient left one bit; subtract divisor if it does not go negative; set quotient bit.
- FIXUP (one cycle):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; negate the remainder if the dividend was negative.
  - Select the result:
    - mul: low half of the product.
    - mulh*: high half of the product.
    - div*/rem*: quotient or remainder.
  - Word results: sign-extend bit 31 to XLEN. This also applies to divuw/remuw.
- DONE: done=1 and result valid; return to IDLE next cycle.
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIXUP. This makes stall 0 in the DONE cycle, so the pipeline advances with the result.
- start while busy is ignored; the pipeline cannot present a new op while stalled.
- flush in any state:
  - Next state is IDLE, done=0, result unchanged.
  - flush overrides start in the same cycle (no accept).

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0, done 0, busy 0, result 0. stall evaluates to 0 because the state is IDLE. Reset mid-operation discards the operation.
- Normal op accepted at edge cycle 0:
  - CALC occupies cycles 1..N; FIXUP is cycle N+1; DONE (done=1) is cycle N+2.
  - XLEN=64: done at cycle 66, or 34 for word ops.
- Special case: done at cycle 1.
- stall is high from cycle 0 through cycle N+1 (cycle 0 only for special cases) and low in the DONE cycle.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.
- All arithmetic is modulo 2^XLEN. Negation is two's complement. Magnitude of the most-negative value is the same bit pattern, interpreted unsigned.

## Test plan
- mul, op_a=7, op_b=−3 (0xFFFF_FFFF_FFFF_FFFD) → done at cycle 66, result=0xFFFF_FFFF_FFFF_FFEB; stall high cycles 0–65.
- mulhu, op_a=op_b=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF_FFFF_FFFE. mulh, op_a=op_b=−1 → result=0.
- div, op_a=−7, op_b=2 → result −3. rem, same operands → result −1. divu, op_a=100, op_b=0 → done at cycle 1, result all ones. remu, op_a=100, op_b=0 → result=100.
- div, op_a=0x8000_0000_0000_0000, op_b=−1 → done at cycle 1, result=0x8000_0000_0000_0000. rem, same operands → result 0.
- divuw, op_a=0x1_8000_0000, op_b=1 → done at cycle 34, result=0xFFFF_FFFF_8000_0000. mulw, op_a=0x7FFF_FFFF, op_b=2 → result=0xFFFF_FFFF_FFFF_FFFE.
- Operation flushes:
  - flush asserted at cycle 10 of a div → IDLE at cycle 11, no done pulse, stall low from cycle 11.
  - start together with flush in IDLE → not accepted.
  - rst_n=0 at cycle 20 → all outputs 0 at cycle 21.
